// File: rtl/multibyte_alu_sequencer.sv
// Multi-byte ALU sequencer: runs a full-width operation one byte per cycle
// through an external 8-bit ALU, chaining the carry from byte to byte.
module multibyte_alu_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic [1:0]            sel,
    input  logic                  cin,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [1:0]            alu_s,
    output logic                  alu_cin,
    input  logic [7:0]            alu_is,
    input  logic                  alu_cout,
    input  logic                  alu_ov,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic                  ov,
    output logic                  zero,
    output logic                  busy,
    output logic                  done
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [1:0]     sel_q, sel_d;
    logic           cin_q, cin_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   result_q, result_d;
    logic           cout_q, cout_d;
    logic           ov_q, ov_d;
    logic           zero_q, zero_d;

    logic           accept;
    logic           last;

    assign accept = (state_q == S_IDLE) && start;
    assign last   = (idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (last)  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: latch operands, write one result byte per RUN cycle
    always_comb begin
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        cin_d    = cin_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ov_d     = ov_q;
        zero_d   = zero_q;
        if (accept) begin
            a_d   = op_a;
            b_d   = op_b;
            sel_d = sel;
            cin_d = cin;
            idx_d = '0;
        end else if (state_q == S_RUN) begin
            result_d[8*idx_q +: 8] = alu_is;
            carry_d = alu_cout;
            if (last) begin
                idx_d  = '0;
                cout_d = alu_cout;
                ov_d   = alu_ov;
                // Zero flag uses the fully assembled word, including this byte
                zero_d = (result_d == '0);
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            cin_q    <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ov_q     <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            cin_q    <= cin_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ov_q     <= ov_d;
            zero_q   <= zero_d;
        end
    end

    // Outputs: ALU is only driven while running, otherwise quiet at zero
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        alu_a   = '0;
        alu_b   = '0;
        alu_s   = '0;
        alu_cin = 1'b0;
        unique case (state_q)
            S_RUN: begin
                busy    = 1'b1;
                alu_a   = a_q[8*idx_q +: 8];
                alu_b   = b_q[8*idx_q +: 8];
                alu_s   = sel_q;
                alu_cin = (idx_q == '0) ? cin_q : carry_q;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign ov     = ov_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_multibyte_alu_sequencer.sv
// Bench for multibyte_alu_sequencer: behavioural 8-bit ALU plus a
// full-width reference model of each operation.
module tb_multibyte_alu_sequencer;

    logic        clk;
    logic        rst;

    logic        start;
    logic [31:0] op_a, op_b;
    logic [1:0]  sel;
    logic        cin;
    logic [7:0]  alu_a, alu_b, alu_is;
    logic [1:0]  alu_s;
    logic        alu_cin, alu_cout, alu_ov;
    logic [31:0] result;
    logic        cout, ov, zero, busy, done;

    logic        start2;
    logic [15:0] op_a2, op_b2;
    logic [1:0]  sel2;
    logic        cin2;
    logic [7:0]  alu_a2, alu_b2, alu_is2;
    logic [1:0]  alu_s2;
    logic        alu_cin2, alu_cout2, alu_ov2;
    logic [15:0] result2;
    logic        cout2, ov2, zero2, busy2, done2;

    int total = 0;
    int bad = 0;

    multibyte_alu_sequencer #(.NBYTES(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .op_a(op_a), .op_b(op_b), .sel(sel), .cin(cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
        .alu_is(alu_is), .alu_cout(alu_cout), .alu_ov(alu_ov),
        .result(result), .cout(cout), .ov(ov), .zero(zero),
        .busy(busy), .done(done)
    );

    multibyte_alu_sequencer #(.NBYTES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .op_a(op_a2), .op_b(op_b2), .sel(sel2), .cin(cin2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_s(alu_s2), .alu_cin(alu_cin2),
        .alu_is(alu_is2), .alu_cout(alu_cout2), .alu_ov(alu_ov2),
        .result(result2), .cout(cout2), .ov(ov2), .zero(zero2),
        .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit ALU: 0 add, 1 subtract (a + ~b + cin), 2 and, 3 xor
    function automatic logic [9:0] alu8(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] s, input logic c);
        logic [8:0] t;
        logic [7:0] bb;
        logic       o;
        t = '0;
        o = 1'b0;
        bb = (s == 2'd1) ? ~b : b;
        case (s)
            2'd0, 2'd1: begin
                t = {1'b0, a} + {1'b0, bb} + {8'd0, c};
                o = (a[7] == bb[7]) && (t[7] != a[7]);
            end
            2'd2: t = {1'b0, a & b};
            default: t = {1'b0, a ^ b};
        endcase
        return {o, t[8], t[7:0]};
    endfunction

    always_comb {alu_ov, alu_cout, alu_is} = alu8(alu_a, alu_b, alu_s, alu_cin);
    always_comb {alu_ov2, alu_cout2, alu_is2} = alu8(alu_a2, alu_b2, alu_s2, alu_cin2);

    // Full-width reference: returns {ov, cout, result}
    function automatic logic [65:0] ref_op(input int n, input logic [63:0] a_in,
                                           input logic [63:0] b_in,
                                           input logic [1:0] s, input logic c);
        logic [63:0] mask, a, b, bb, r;
        logic [64:0] t;
        logic        co, o;
        int          w;
        w = 8 * n;
        mask = (n == 8) ? '1 : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        co = 1'b0;
        o = 1'b0;
        r = '0;
        if (s == 2'd0 || s == 2'd1) begin
            bb = (s == 2'd1) ? (~b & mask) : b;
            t = {1'b0, a} + {1'b0, bb} + {64'd0, c};
            r = t[63:0] & mask;
            co = t[w];
            o = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
        end else if (s == 2'd2) begin
            r = a & b;
        end else begin
            r = a ^ b;
        end
        return {o, co, r};
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Issue one op on the 4-byte DUT; lat = -1 when done never arrives
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] s, input logic c,
                          output int lat);
        wait_idle();
        op_a = a; op_b = b; sel = s; cin = c; start = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
            start = 1'b0;
            op_a = $urandom;
            op_b = $urandom;
            sel = 2'($urandom);
            cin = 1'($urandom);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({result, cout, ov, zero, busy, done} !== 37'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {result, cout, ov, zero, busy, done});
        end
        total++;
        if ({alu_a, alu_b, alu_s, alu_cin} !== 19'd0) begin
            bad++;
            $display("FAIL reset_alu_bus got=%h exp=0", {alu_a, alu_b, alu_s, alu_cin});
        end
        total++;
        if ({result2, busy2, done2} !== 18'd0) begin
            bad++;
            $display("FAIL reset_dut2 got=%h exp=0", {result2, busy2, done2});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] da[4], db[4];
        logic [31:0] er[4];
        logic [3:0]  ec, eo, ez;
        logic [31:0] held;
        int lat;
        da = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h12345678};
        db = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000};
        er = '{32'h00000100, 32'h00000000, 32'h80000000, 32'h00000000};
        ec = 4'b0010;
        eo = 4'b0100;
        ez = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            run_op(da[k], db[k], (k == 3) ? 2'd2 : 2'd0, 1'b0, lat);
            total++;
            if (lat != 5) begin
                bad++;
                $display("FAIL dir%0d_latency got=%0d exp=5", k, lat);
            end
            total++;
            if ({result, cout, ov, zero} !== {er[k], ec[k], eo[k], ez[k]}) begin
                bad++;
                $display("FAIL dir%0d_result got=%h/%b%b%b exp=%h/%b%b%b", k,
                         result, cout, ov, zero, er[k], ec[k], eo[k], ez[k]);
            end
            held = result;
            repeat (3) begin
                @(posedge clk);
                #1;
                total++;
                if (done !== 1'b0 || result !== held || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL dir%0d_hold got=%h done=%b busy=%b exp=%h done=0 busy=0",
                             k, result, done, busy, held);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [1:0]  s;
        logic        c;
        logic [65:0] e;
        int lat;
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            b = $urandom;
            s = 2'($urandom);
            c = 1'($urandom);
            if (k % 8 == 0) begin
                s = 2'd0;
                c = 1'b0;
                b = 32'd0 - a;
            end
            e = ref_op(4, {32'd0, a}, {32'd0, b}, s, c);
            run_op(a, b, s, c, lat);
            total++;
            if (lat != 5 || result !== e[31:0] || cout !== e[64] || ov !== e[65] ||
                zero !== (e[31:0] == 32'd0)) begin
                bad++;
                $display("FAIL rand%0d got=%h c%b v%b z%b lat%0d exp=%h c%b v%b z%b lat5",
                         k, result, cout, ov, zero, lat, e[31:0], e[64], e[65],
                         (e[31:0] == 32'd0));
            end
        end
        wait_idle();
        total++;
        if ({alu_a, alu_b, alu_s, alu_cin} !== 19'd0) begin
            bad++;
            $display("FAIL idle_alu_bus got=%h exp=0", {alu_a, alu_b, alu_s, alu_cin});
        end
    endtask

    task automatic test_partial();
        logic [31:0] prev, a, b;
        logic [65:0] e;
        int n;
        wait_idle();
        prev = result;
        a = $urandom;
        b = $urandom;
        e = ref_op(4, {32'd0, a}, {32'd0, b}, 2'd3, 1'b0);
        op_a = a; op_b = b; sel = 2'd3; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (result !== {prev[31:8], e[7:0]}) begin
            bad++;
            $display("FAIL partial_bytes got=%h exp=%h", result, {prev[31:8], e[7:0]});
        end
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (!done || result !== e[31:0]) begin
            bad++;
            $display("FAIL partial_final got=%h done=%b exp=%h done=1", result, done, e[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa[17], pb[17];
        int          de[$];
        logic [31:0] dr[$];
        logic [65:0] e;
        wait_idle();
        sel = 2'd0;
        cin = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        start = 1'b1;
        for (int ed = 1; ed <= 16; ed++) begin
            pa[ed] = op_a;
            pb[ed] = op_b;
            @(posedge clk);
            #1;
            if (done) begin
                de.push_back(ed);
                dr.push_back(result);
            end
            @(negedge clk);
            if (ed >= 10) start = 1'b0;
            op_a = $urandom;
            op_b = $urandom;
        end
        total++;
        if (de.size() != 2) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=2", de.size());
        end else begin
            total++;
            if (de[0] != 5 || de[1] != 11) begin
                bad++;
                $display("FAIL b2b_spacing got=%0d,%0d exp=5,11", de[0], de[1]);
            end
            e = ref_op(4, {32'd0, pa[1]}, {32'd0, pb[1]}, 2'd0, 1'b0);
            total++;
            if (dr[0] !== e[31:0]) begin
                bad++;
                $display("FAIL b2b_op1 got=%h exp=%h", dr[0], e[31:0]);
            end
            e = ref_op(4, {32'd0, pa[7]}, {32'd0, pb[7]}, 2'd0, 1'b0);
            total++;
            if (dr[1] !== e[31:0]) begin
                bad++;
                $display("FAIL b2b_op2 got=%h exp=%h", dr[1], e[31:0]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int ndone;
        int lat;
        wait_idle();
        op_a = 32'hDEADBEEF; op_b = 32'h01010101; sel = 2'd0; cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy_before got=%b exp=1", busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({result, cout, ov, zero, busy, done, alu_a, alu_cin} !== 46'd0) begin
            bad++;
            $display("FAIL abort_cleared got=%h exp=0",
                     {result, cout, ov, zero, busy, done, alu_a, alu_cin});
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL abort_no_done got=%0d exp=0", ndone);
        end
        run_op(32'h00000FFF, 32'h00000001, 2'd0, 1'b0, lat);
        total++;
        if (lat != 5 || result !== 32'h00001000) begin
            bad++;
            $display("FAIL abort_restart got=%h lat%0d exp=00001000 lat5", result, lat);
        end
    endtask

    task automatic test_nbytes2();
        logic [15:0] a, b;
        logic [65:0] e;
        int lat;
        for (int k = 0; k < 6; k++) begin
            a = (k == 0) ? 16'h00FF : 16'($urandom);
            b = (k == 0) ? 16'h0001 : 16'($urandom);
            sel2 = (k == 0) ? 2'd0 : 2'($urandom);
            cin2 = (k == 0) ? 1'b0 : 1'($urandom);
            e = ref_op(2, {48'd0, a}, {48'd0, b}, sel2, cin2);
            @(negedge clk);
            op_a2 = a; op_b2 = b; start2 = 1'b1;
            lat = -1;
            for (int i = 1; i <= 12; i++) begin
                @(posedge clk);
                #1;
                if (done2) begin
                    lat = i;
                    break;
                end
                @(negedge clk);
                start2 = 1'b0;
                op_a2 = 16'($urandom);
            end
            start2 = 1'b0;
            total++;
            if (lat != 3 || result2 !== e[15:0] || cout2 !== e[64] || ov2 !== e[65]) begin
                bad++;
                $display("FAIL nb2_op%0d got=%h c%b v%b lat%0d exp=%h c%b v%b lat3",
                         k, result2, cout2, ov2, lat, e[15:0], e[64], e[65]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        start = 1'b0; op_a = '0; op_b = '0; sel = '0; cin = 1'b0;
        start2 = 1'b0; op_a2 = '0; op_b2 = '0; sel2 = '0; cin2 = 1'b0;
        rst = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_partial();
        test_back_to_back();
        test_reset_abort();
        test_nbytes2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
